// File: rtl/direction_input_conditioner.sv
// direction_input_conditioner
//
// Front end between four raw direction push-buttons and the room FSM.
// Each button has its own channel: a two-flop synchroniser, a debouncer, and
// rising-edge detection on the debounced level. Press events from the four
// channels go through a fixed-priority arbiter (N > S > E > W). At most one
// registered one-cycle direction pulse appears per clock. Events that lose
// arbitration are discarded, and this is flagged on 'dropped'.
//
// Optional feature (macro DIR_REPEAT_EN): a held button auto-repeats every
// REPEAT_CYCLES cycles. Repeat events use the same arbitration as presses.
//
// Parameters
//   DEBOUNCE_CYCLES  cycles a synchronised level must differ from the
//                    debounced level before that level flips (>= 2)
//   REPEAT_CYCLES    auto-repeat interval, used only with DIR_REPEAT_EN (>= 2)
//
// Ports
//   clk                        system clock, all logic on posedge
//   reset                      synchronous active-high reset, clears all state
//   btn_n, btn_s, btn_e, btn_w raw asynchronous buttons, active-high
//   N, S, E, W                 registered one-cycle direction pulses, one-hot-or-zero
//   dropped                    registered pulse: an event was lost to arbitration
//
// Handshake: none. Outputs are fire-and-forget strobes. The consumer must
// sample them on every clock, because nothing holds them or applies backpressure.
module direction_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic btn_s,
  input  logic btn_e,
  input  logic btn_w,
  output logic N,
  output logic S,
  output logic E,
  output logic W,
  output logic dropped
);

  // Elaboration-time parameter sanity checks.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be >= 2");
  end

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Channel index: 0 = N, 1 = S, 2 = E, 3 = W (bit 0 has the highest priority).
  logic [3:0] raw;
  assign raw = {btn_w, btn_e, btn_s, btn_n};

  logic [3:0]    s1_q, s2_q;
  logic [3:0]    deb_q, deb_d;
  logic [3:0]    deb_prev_q;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  logic [3:0] press_ev;
  logic [3:0] rep_ev;
  logic [3:0] any_ev;
  logic [3:0] grant;
  logic [3:0] dir_q;
  logic       dropped_q;
  logic       dropped_d;

  // Debounce: progress accumulates only while s2 differs from deb on
  // consecutive cycles. Any cycle of agreement restarts the count, so a
  // one-cycle glitch never flips the level.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign press_ev = deb_q & ~deb_prev_q;

`ifdef DIR_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_q [4];
  logic [RW-1:0] rep_d [4];

  // The repeat counter is zeroed on the press cycle and while the button is
  // released. It runs only while the debounced level stays high. On each
  // wrap it produces one repeat event, so repeats land every REPEAT_CYCLES
  // after the press pulse.
  always_comb begin
    rep_ev = '0;
    for (int i = 0; i < 4; i++) begin
      rep_d[i] = rep_q[i];
      if (!deb_q[i] || press_ev[i]) begin
        rep_d[i] = '0;
      end else if (rep_q[i] == REP_MAX) begin
        rep_d[i]  = '0;
        rep_ev[i] = 1'b1;
      end else begin
        rep_d[i] = rep_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) rep_q[i] <= '0;
      else       rep_q[i] <= rep_d[i];
    end
  end
`else
  assign rep_ev = '0;
`endif

  assign any_ev = press_ev | rep_ev;

  // Fixed-priority arbitration: the lowest set bit wins.
  always_comb begin
    grant = 4'b0000;
    if      (any_ev[0]) grant = 4'b0001;
    else if (any_ev[1]) grant = 4'b0010;
    else if (any_ev[2]) grant = 4'b0100;
    else if (any_ev[3]) grant = 4'b1000;
    dropped_d = |(any_ev & ~grant);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      dir_q      <= '0;
      dropped_q  <= 1'b0;
    end else begin
      s1_q       <= raw;
      s2_q       <= s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      dir_q      <= grant;
      dropped_q  <= dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) cnt_q[i] <= '0;
      else       cnt_q[i] <= cnt_d[i];
    end
  end

  assign N       = dir_q[0];
  assign S       = dir_q[1];
  assign E       = dir_q[2];
  assign W       = dir_q[3];
  assign dropped = dropped_q;

endmodule
